// File: rtl/pc_ctrl_if.sv
// Execute-to-fetch control bundle for pc_ctrl: redirect/hold requests in,
// fetch PC plus pipeline flush/stall and perf counters out.
interface pc_ctrl_if;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic        ext_hold_i;
  logic [31:0] pc_o;
  logic        flush_o;
  logic        stall_o;
  logic [31:0] jump_cnt_o;
  logic [31:0] stall_cnt_o;

  modport master (
    output jump_en_i, jump_addr_i, hold_flag_i, ext_hold_i,
    input  pc_o, flush_o, stall_o, jump_cnt_o, stall_cnt_o
  );

  modport slave (
    input  jump_en_i, jump_addr_i, hold_flag_i, ext_hold_i,
    output pc_o, flush_o, stall_o, jump_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/pc_ctrl.sv
// Program counter and pipeline flush/stall control for the three-stage core.
// Optional perf counters are built when PC_CTRL_PERF_EN is defined.
module pc_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP    = 32'd4
) (
  input  logic       clk,
  input  logic       rst,
  pc_ctrl_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic        in_pend_s;
  logic        flush_s;
  logic        stall_s;

  assign in_pend_s = (state_q == ST_PEND);

  // Next-state and next-PC selection in redirect priority order.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_addr_d = pend_addr_q;
    if (bus.jump_en_i && !bus.ext_hold_i) begin
      // The newest redirect wins, so a pending one is simply dropped.
      pc_d    = bus.jump_addr_i;
      state_d = ST_RUN;
    end else if (bus.jump_en_i && bus.ext_hold_i) begin
      pend_addr_d = bus.jump_addr_i;
      state_d     = ST_PEND;
    end else if (in_pend_s && !bus.ext_hold_i) begin
      pc_d    = pend_addr_q;
      state_d = ST_RUN;
    end else if (bus.hold_flag_i || bus.ext_hold_i || in_pend_s) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // State, PC and pending-target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_ADDR;
      pend_addr_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  // Flush always beats stall so the two are mutually exclusive.
  always_comb begin
    flush_s = 1'b0;
    stall_s = 1'b0;
    if (rst) begin
      flush_s = 1'b0;
      stall_s = 1'b1;
    end else if (bus.jump_en_i) begin
      flush_s = 1'b1;
      stall_s = 1'b0;
    end else begin
      flush_s = 1'b0;
      stall_s = bus.hold_flag_i | bus.ext_hold_i | in_pend_s;
    end
  end

  assign bus.pc_o    = pc_q;
  assign bus.flush_o = flush_s;
  assign bus.stall_o = stall_s;

`ifdef PC_CTRL_PERF_EN
  logic [31:0] jump_cnt_q, jump_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Wrapping event counters for taken redirects and stalled cycles.
  always_comb begin
    jump_cnt_d  = jump_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_s) begin
      jump_cnt_d = jump_cnt_q + 32'd1;
    end else begin
      jump_cnt_d = jump_cnt_q;
    end
    if (stall_s && !rst) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      jump_cnt_q  <= 32'h0000_0000;
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      jump_cnt_q  <= jump_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.jump_cnt_o  = jump_cnt_q;
  assign bus.stall_cnt_o = stall_cnt_q;
`else
  assign bus.jump_cnt_o  = 32'h0000_0000;
  assign bus.stall_cnt_o = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: a transaction-level model checked every cycle
// plus literal expectations from the worked scenarios.
module tb_pc_ctrl;

  localparam logic [31:0] RST_A = 32'h0000_0100;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  bit   check_en;

  pc_ctrl_if bus ();

  pc_ctrl #(.RESET_ADDR(RST_A), .PC_STEP(32'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: architectural PC, at most one waiting redirect, event tallies.
  logic [31:0] m_pc;
  bit          m_has_pend;
  logic [31:0] m_pend;
  logic [31:0] m_jumps;
  logic [31:0] m_stalls;

  function automatic bit exp_flush();
    return bus.jump_en_i && !rst;
  endfunction

  function automatic bit exp_stall();
    if (rst) return 1'b1;
    if (bus.jump_en_i) return 1'b0;
    return bus.hold_flag_i || bus.ext_hold_i || m_has_pend;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pc       <= RST_A;
      m_has_pend <= 1'b0;
      m_pend     <= 32'h0;
      m_jumps    <= 32'h0;
      m_stalls   <= 32'h0;
    end else begin
      if (exp_flush()) m_jumps <= m_jumps + 32'd1;
      if (exp_stall()) m_stalls <= m_stalls + 32'd1;
      if (bus.jump_en_i) begin
        if (bus.ext_hold_i) begin
          m_has_pend <= 1'b1;
          m_pend     <= bus.jump_addr_i;
        end else begin
          m_has_pend <= 1'b0;
          m_pc       <= bus.jump_addr_i;
        end
      end else if (m_has_pend) begin
        if (!bus.ext_hold_i) begin
          m_has_pend <= 1'b0;
          m_pc       <= m_pend;
        end
      end else if (!bus.hold_flag_i && !bus.ext_hold_i) begin
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef PC_CTRL_PERF_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("pc", bus.pc_o, m_pc);
      check("flush", {31'h0, bus.flush_o}, {31'h0, exp_flush()});
      check("stall", {31'h0, bus.stall_o}, {31'h0, exp_stall()});
      check("excl", {31'h0, bus.flush_o & bus.stall_o}, 32'h0);
      check("jump_cnt", bus.jump_cnt_o, perf(m_jumps));
      check("stall_cnt", bus.stall_cnt_o, perf(m_stalls));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    check_en = 1'b0;
    rst = 1'b1;
    bus.jump_en_i   = 1'b0;
    bus.jump_addr_i = 32'h0;
    bus.hold_flag_i = 1'b0;
    bus.ext_hold_i  = 1'b0;
    step();
    check_en = 1'b1;
    step();
    check("rst_pc", bus.pc_o, 32'h100);
    check("rst_stall", {31'h0, bus.stall_o}, 32'h1);
    check("rst_flush", {31'h0, bus.flush_o}, 32'h0);

    // Sequential fetch after reset release.
    rst = 1'b0;
    #1;
    check("seq0", bus.pc_o, 32'h100);
    check("seq_stall", {31'h0, bus.stall_o}, 32'h0);
    step(); check("seq1", bus.pc_o, 32'h104);
    step(); check("seq2", bus.pc_o, 32'h108);

    // Single-cycle redirect.
    bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'h200;
    #1; check("jmp_flush", {31'h0, bus.flush_o}, 32'h1);
    step(); bus.jump_en_i = 1'b0;
    check("jmp_pc", bus.pc_o, 32'h200);
    step(); check("jmp_pc_next", bus.pc_o, 32'h204);

    // Three-cycle execute hold at 0x20.
    bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'h20;
    step(); bus.jump_en_i = 1'b0;
    bus.hold_flag_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_pc", bus.pc_o, 32'h20);
      check("hold_stall", {31'h0, bus.stall_o}, 32'h1);
      step();
    end
    bus.hold_flag_i = 1'b0;
    check("hold_end_pc", bus.pc_o, 32'h20);
    check("hold_stall_cnt", bus.stall_cnt_o, perf(32'd3));
    step(); check("hold_resume", bus.pc_o, 32'h24);

    // Two redirects under a bus hold: the newer one wins.
    bus.ext_hold_i = 1'b1; bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'h400;
    #1; check("pend_flush1", {31'h0, bus.flush_o}, 32'h1);
    step(); bus.jump_addr_i = 32'h500;
    #1; check("pend_flush2", {31'h0, bus.flush_o}, 32'h1);
    check("pend_frozen1", bus.pc_o, 32'h24);
    step(); bus.jump_en_i = 1'b0;
    step();
    step(); bus.ext_hold_i = 1'b0;
    #1; check("pend_frozen2", bus.pc_o, 32'h24);
    check("pend_stall", {31'h0, bus.stall_o}, 32'h1);
    step();
    check("pend_apply", bus.pc_o, 32'h500);
    check("pend_jump_cnt", bus.jump_cnt_o, perf(32'd4));
    check("pend_stall_cnt", bus.stall_cnt_o, perf(32'd6));
    step(); check("pend_next", bus.pc_o, 32'h504);

    // Wrap at the top of the address space.
    bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'hFFFF_FFFC;
    step(); bus.jump_en_i = 1'b0;
    check("wrap_top", bus.pc_o, 32'hFFFF_FFFC);
    step(); check("wrap_zero", bus.pc_o, 32'h0);

    // Reset while a redirect is pending discards it.
    bus.ext_hold_i = 1'b1; bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'h600;
    step(); bus.jump_en_i = 1'b0;
    rst = 1'b1;
    step();
    check("pend_rst_pc", bus.pc_o, 32'h100);
    check("pend_rst_jcnt", bus.jump_cnt_o, 32'h0);
    check("pend_rst_scnt", bus.stall_cnt_o, 32'h0);
    rst = 1'b0; bus.ext_hold_i = 1'b0;
    step(); check("post_rst1", bus.pc_o, 32'h104);
    step(); check("post_rst2", bus.pc_o, 32'h108);
    step();
    check_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
